// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Brief    : Elaboration-configurable UART receiver (5-9 data bits, none/odd/
//             even parity, 1-2 stop bits) with input synchroniser, start-glitch
//             rejection, parity/framing flags and break recovery.
//             Optional 2-of-3 majority sampling: define UART_RX_MAJORITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLK_FRQ   = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 axiid,
    output logic                 axiov,
    output logic [DATA_BITS-1:0] axiod,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int CYCLES_PER_BIT = CLK_FRQ / BAUD;
    localparam int HALF_CYCLE     = CYCLES_PER_BIT >> 1;
    localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
    localparam int BW             = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    // Majority mode commits one cycle late; reloading at 2 keeps bit spacing.
    localparam logic [CW-1:0] C_HALF   = CW'(HALF_CYCLE + SKEW);
    localparam logic [CW-1:0] C_FULL   = CW'(CYCLES_PER_BIT + SKEW);
    localparam logic [CW-1:0] C_RELOAD = CW'(1 + SKEW);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [CW-1:0]         count_q;
    logic [BW-1:0]         bit_idx_q;
    logic                  stop_idx_q;
    logic [DATA_BITS-1:0]  shreg_q;
    logic                  xor_q;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  axiov_q;
    logic [DATA_BITS-1:0]  axiod_q;
    logic                  parity_err_q;
    logic                  frame_err_q;
    logic                  w_rx_s;
    logic                  w_bit;

    assign w_rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], axiid};
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], w_rx_s};
    end

    assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & w_rx_s) | (hist_q[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            xor_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            axiov_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        state_q   <= S_START;
                        count_q   <= CW'(1);
                        bit_idx_q <= '0;
                    end
                end
                S_START: begin
                    if (count_q == C_HALF) begin
                        if (w_bit) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_DATA;
                            count_q    <= C_RELOAD;
                            shreg_q    <= '0;
                            xor_q      <= 1'b0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            stop_idx_q <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (count_q == C_FULL) begin
                        shreg_q[bit_idx_q] <= w_bit;
                        xor_q              <= xor_q ^ w_bit;
                        count_q            <= C_RELOAD;
                        if (bit_idx_q == BW'(DATA_BITS - 1))
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (count_q == C_FULL) begin
                        perr_q  <= (PARITY == 1) ? ~(xor_q ^ w_bit) : (xor_q ^ w_bit);
                        count_q <= C_RELOAD;
                        state_q <= S_STOP;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (count_q == C_FULL) begin
                        ferr_q <= ferr_q | ~w_bit;
                        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                            state_q      <= S_DONE;
                            axiov_q      <= 1'b1;
                            axiod_q      <= shreg_q;
                            parity_err_q <= perr_q;
                            frame_err_q  <= ferr_q | ~w_bit;
                        end else begin
                            stop_idx_q <= 1'b1;
                            count_q    <= C_RELOAD;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= ferr_q ? S_WAIT_HIGH : S_IDLE;
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg
//  Brief    : Self-checking bench for uart_rx_cfg; four receivers with
//             different frame formats share one clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;
    localparam int CPB  = 16;
    localparam int HALF = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 156;
`else
    localparam int LAT = 155;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        logic [31:0] t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rx_line = 4'hF;
    logic [3:0]  ov, pe, fe;
    logic [7:0]  od0;
    logic [6:0]  od1;
    logic [7:0]  od2;
    logic [8:0]  od3;
    logic [31:0] cyc = 0;
    logic [31:0] last_start = 0;
    int          checks = 0;
    int          errors = 0;
    rec_t        recq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLK_FRQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .axiid(rx_line[0]), .axiov(ov[0]), .axiod(od0),
        .parity_err(pe[0]), .frame_err(fe[0]));
    uart_rx_cfg #(.CLK_FRQ(160), .BAUD(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .axiid(rx_line[1]), .axiov(ov[1]), .axiod(od1),
        .parity_err(pe[1]), .frame_err(fe[1]));
    uart_rx_cfg #(.CLK_FRQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .axiid(rx_line[2]), .axiov(ov[2]), .axiod(od2),
        .parity_err(pe[2]), .frame_err(fe[2]));
    uart_rx_cfg #(.CLK_FRQ(160), .BAUD(10), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .axiid(rx_line[3]), .axiov(ov[3]), .axiod(od3),
        .parity_err(pe[3]), .frame_err(fe[3]));

    // Every valid pulse from any receiver is logged with its cycle stamp.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ov[k] === 1'b1) begin
                rec_t r;
                r.id = 2'(k);
                case (k)
                    0:       r.d = {1'b0, od0};
                    1:       r.d = {2'b0, od1};
                    2:       r.d = {1'b0, od2};
                    default: r.d = od3;
                endcase
                r.pe = pe[k];
                r.fe = fe[k];
                r.t  = cyc;
                recq.push_back(r);
            end
        end
    end

    function automatic int db(input int id);
        case (id) 0: return 8; 1: return 7; 2: return 8; default: return 9; endcase
    endfunction
    function automatic int par(input int id);
        case (id) 1: return 2; 3: return 1; default: return 0; endcase
    endfunction
    function automatic int sb(input int id);
        return (id >= 2) ? 2 : 1;
    endfunction
    function automatic logic [8:0] mask(input int id, input logic [8:0] d);
        return d & 9'((1 << db(id)) - 1);
    endfunction
    // Parity bit that makes the frame correct for the receiver's mode.
    function automatic logic good_par(input int id, input logic [8:0] d);
        int ones = 0;
        for (int b = 0; b < db(id); b++) ones += int'(d[b]);
        return (par(id) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int id, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input bit spike);
        last_start = cyc;
        rx_line[id] = 1'b0;
        tick(CPB);
        for (int b = 0; b < db(id); b++) begin
            rx_line[id] = data[b];
            if (spike) begin
                tick(HALF);
                rx_line[id] = ~data[b];
                tick(1);
                rx_line[id] = data[b];
                tick(CPB - HALF - 1);
            end else begin
                tick(CPB);
            end
        end
        if (par(id) != 0) begin
            rx_line[id] = pbit;
            tick(CPB);
        end
        rx_line[id] = stops[0];
        tick(CPB);
        if (sb(id) == 2) begin
            rx_line[id] = stops[1];
            tick(CPB);
        end
    endtask

    task automatic check_frame(input string tag, input int id, input logic [8:0] d,
                               input logic epe, input logic efe, output rec_t r);
        for (int i = 0; i < 400 && recq.size() == 0; i++) tick(1);
        r = '0;
        if (recq.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = recq.pop_front();
            chk({tag, "_id"}, 32'(r.id), 32'(id));
            chk({tag, "_data"}, 32'(r.d), 32'(mask(id, d)));
            chk({tag, "_perr"}, 32'(r.pe), 32'(epe));
            chk({tag, "_ferr"}, 32'(r.fe), 32'(efe));
        end
    endtask

    initial begin
        rec_t        r;
        logic [31:0] t0;
        logic [8:0]  d;
        logic [1:0]  stops;
        logic        flip, pb, epe, efe;
        int          id;

        tick(3);
        chk("rst_axiov", 32'(ov), 32'd0);
        chk("rst_axiod", 32'({od3, od2, od1, od0}), 32'd0);
        chk("rst_perr", 32'(pe), 32'd0);
        chk("rst_ferr", 32'(fe), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Back-to-back 8N1 frames, no idle gap.
        send_frame(0, 9'hA5, 1'b0, 2'b11, 1'b0);
        t0 = last_start;
        send_frame(0, 9'h3C, 1'b0, 2'b11, 1'b0);
        check_frame("b2b_a5", 0, 9'hA5, 1'b0, 1'b0, r);
        chk("b2b_latency", r.t - t0, 32'(LAT));
        check_frame("b2b_3c", 0, 9'h3C, 1'b0, 1'b0, r);
        tick(10);
        chk("hold_axiod", 32'(od0), 32'h3C);

        // 7E1: correct parity then wrong parity.
        send_frame(1, 9'h55, 1'b0, 2'b11, 1'b0);
        check_frame("even_ok", 1, 9'h55, 1'b0, 1'b0, r);
        tick(CPB);
        send_frame(1, 9'h55, 1'b1, 2'b11, 1'b0);
        check_frame("even_bad", 1, 9'h55, 1'b1, 1'b0, r);
        tick(CPB);

        // 8N2 with second stop low, then a held-low line.
        send_frame(2, 9'h81, 1'b0, 2'b01, 1'b0);
        tick(40);
        check_frame("stop2_low", 2, 9'h81, 1'b0, 1'b1, r);
        chk("break_no_extra", 32'(recq.size()), 32'd0);
        rx_line[2] = 1'b1;
        tick(5);
        send_frame(2, 9'h3C, 1'b0, 2'b11, 1'b0);
        check_frame("after_break", 2, 9'h3C, 1'b0, 1'b0, r);
        tick(CPB);

        // Short low glitch on an idle line.
        rx_line[0] = 1'b0;
        tick(3);
        rx_line[0] = 1'b1;
        tick(40);
        chk("glitch_no_out", 32'(recq.size()), 32'd0);
        send_frame(0, 9'h0F, 1'b0, 2'b11, 1'b0);
        check_frame("after_glitch", 0, 9'h0F, 1'b0, 1'b0, r);
        tick(CPB);

        // Reset in the middle of data bit 3; released once the line is high.
        fork
            send_frame(0, 9'hF0, 1'b0, 2'b11, 1'b0);
            begin
                tick(CPB + 3 * CPB + HALF);
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_axiov", 32'(ov[0]), 32'd0);
                chk("midrst_axiod", 32'(od0), 32'd0);
                chk("midrst_flags", 32'({pe[0], fe[0]}), 32'd0);
                tick(10);
                rst_n = 1'b1;
            end
        join
        tick(20);
        chk("midrst_no_out", 32'(recq.size()), 32'd0);
        send_frame(0, 9'hFF, 1'b0, 2'b11, 1'b0);
        check_frame("after_rst", 0, 9'hFF, 1'b0, 1'b0, r);
        tick(CPB);

        // Single-cycle high spike at each data bit's centre.
`ifdef UART_RX_MAJORITY_EN
        d = 9'h00;
`else
        d = 9'hFF;
`endif
        send_frame(0, 9'h00, 1'b0, 2'b11, 1'b1);
        check_frame("spike", 0, d, 1'b0, 1'b0, r);
        tick(CPB);

        // Random frames against the frame-format model.
        for (int n = 0; n < 16; n++) begin
            id    = int'($urandom_range(0, 3));
            d     = 9'($urandom);
            flip  = ($urandom_range(0, 3) == 0);
            pb    = good_par(id, d) ^ flip;
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            epe   = (par(id) != 0) && flip;
            efe   = !stops[0] || (sb(id) == 2 && !stops[1]);
            send_frame(id, d, pb, stops, 1'b0);
            rx_line[id] = 1'b1;
            check_frame("rand", id, d, epe, efe, r);
            tick(CPB);
        end

        tick(20);
        chk("end_no_extra", 32'(recq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Configurable UART receiver; the next generation of the single-format 8N1 receiver.
- Frame format is set at elaboration: 5–9 data bits, optional odd/even parity, 1 or 2 stop bits.
- Adds an input synchroniser, start-bit glitch rejection, parity and framing error flags, and line-recovery after a bad frame.
- Sits between the board RX pin and the host-side byte consumer; emits one valid pulse per frame.

Parameters:
- CLK_FRQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s. CYCLES_PER_BIT = CLK_FRQ/BAUD, must be at least 8. HALF_CYCLE = CYCLES_PER_BIT>>1.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- axiid  in  1  raw serial line; idles high
- axiov  out  1  one-cycle pulse: frame complete, axiod and error flags valid
- axiod  out  DATA_BITS  received word, LSB first on the wire, bit 0 = first data bit
- parity_err  out  1  parity mismatch; valid with axiov; always 0 when PARITY=0
- frame_err  out  1  a stop bit sampled 0; valid with axiov

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; axiov=0, axiod=0, parity_err=0, frame_err=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the frame; no axiov is produced for it.
- Synchroniser: axiid passes through 2 flops to give rx_s. All decisions use rx_s, so 2 cycles of latency are added to every edge.
- Bit counter: count runs 1..CYCLES_PER_BIT, width $clog2(CYCLES_PER_BIT)+1. bit_idx counts data bits.
- IDLE:
  - rx_s==0 -> START, count=1, bit_idx=0.
- START:
  - When count==HALF_CYCLE, sample rx_s.
  - If the sample is 1 -> IDLE (glitch rejected, no output).
  - If the sample is 0 -> DATA, count=1, shift register cleared.
- DATA:
  - When count==CYCLES_PER_BIT, sample into shreg[bit_idx] and fold the sample into the running XOR.
  - After bit DATA_BITS-1: go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Sample after CYCLES_PER_BIT.
  - Odd mode expects XOR(data)^p==1; even mode expects XOR(data)^p==0. A mismatch sets the internal perr.
- STOP:
  - Sample after CYCLES_PER_BIT; a 0 sets the internal ferr.
  - With STOP_BITS=2, repeat once; either stop bit being 0 sets ferr.
  - After the last stop sample -> DONE.
- DONE (one cycle):
  - axiov=1; axiod=shreg; parity_err=perr; frame_err=ferr.
  - If ferr -> WAIT_HIGH, else -> IDLE.
  - axiod and the error flags hold their values until the next DONE.
- WAIT_HIGH:
  - Stay until rx_s==1, then -> IDLE.
  - This prevents a break or stuck-low line from generating back-to-back false frames.
- Latency: axiov rises 1 cycle after the final stop-bit sample, i.e. 2 (sync) + HALF_CYCLE + (DATA_BITS + P + STOP_BITS)·CYCLES_PER_BIT + 1 cycles after the falling edge of axiid, where P=1 if PARITY!=0 else 0.
- Back-to-back frames: a start edge arriving the cycle after DONE must be caught. No idle gap is required beyond the stop bit(s).
- No backpressure: the consumer must take data on the axiov pulse. Overruns are not detected.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start, data, parity, stop) takes rx_s at count==target-1, target, and target+1.
  - The bit value is the 2-of-3 majority, committed at target+1.
  - All later sample points keep CYCLES_PER_BIT spacing, so overall latency grows by 1 cycle.
  - Start glitch rejection uses the majority value.
- Undefined: single sample at target, exactly as specified above.

Test Plan:
- Bench overrides CLK_FRQ=160, BAUD=10, giving 16 cycles/bit.
- 8N1, send 0xA5 then 0x3C back-to-back with no gap -> two axiov pulses, axiod=0xA5 then 0x3C, both error flags 0; first pulse 2+8+9·16+1=155 cycles after the start edge.
- PARITY=2, DATA_BITS=7, send 0x55 with a correct even-parity bit (0) -> axiod=0x55, parity_err=0. Same data with parity bit 1 -> parity_err=1, axiod=0x55.
- STOP_BITS=2, send 0x81 with the second stop bit driven 0, then the line held low 40 cycles -> one axiov with frame_err=1; no further axiov until the line returns high and a new start is sent.
- 3-cycle low glitch on an idle line -> no axiov, receiver back in IDLE; a following valid 0x0F frame is received correctly.
- Deassert then reassert rst_n at the 4th data bit -> outputs go to 0 asynchronously, no axiov for that frame; the next frame 0xFF is received correctly.
- With UART_RX_MAJORITY_EN, send 0x00 with a 1-cycle high spike at each bit's midpoint -> axiod=0x00, no errors. Without the macro, the spike corrupts the sampled bits.
